// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the register-file responder state type.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

endpackage

// File: rtl/ahblite_byte_strobe.sv
// Byte-lane strobe and alignment check for one AHB transfer.
// Lane decoding is built only under AHBLITE_REGFILE_BYTE_WRITE_EN; otherwise strobe is all lanes.
module ahblite_byte_strobe
  import ahblite_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_strb,
  output logic       o_misalign
);

  always_comb begin
    o_strb     = '1;
    o_misalign = 1'b0;
    case (i_size)
      HSIZE_BYTE: begin
`ifdef AHBLITE_REGFILE_BYTE_WRITE_EN
        o_strb = 4'b0001 << i_addr;
`endif
      end
      HSIZE_HALF: begin
        o_misalign = i_addr[0];
`ifdef AHBLITE_REGFILE_BYTE_WRITE_EN
        o_strb = i_addr[1] ? 4'b1100 : 4'b0011;
`endif
      end
      HSIZE_WORD: o_misalign = |i_addr;
      default:    o_misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahblite_regfile_slave.sv
// AHB-Lite register-file responder: NUM_REGS-1 RW words plus a read-only status word.
// Sub-word writes are legal only when AHBLITE_REGFILE_BYTE_WRITE_EN is defined.
module ahblite_regfile_slave
  import ahblite_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          HSEL,
  input  logic [31:0]                   HADDR,
  input  logic [1:0]                    HTRANS,
  input  logic [2:0]                    HSIZE,
  input  logic                          HWRITE,
  input  logic                          HREADY,
  input  logic [31:0]                   HWDATA,
  output logic                          HREADYOUT,
  output logic                          HRESP,
  output logic [31:0]                   HRDATA,
  output logic [32*(NUM_REGS-1)-1:0]    ctrl_out,
  input  logic [31:0]                   status_in
);

  localparam int unsigned IDXW = $clog2(NUM_REGS);

  ahb_state_e        r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_pend, r_write;
  logic [IDXW-1:0]   r_idx;
  logic [3:0]        r_strb;
  logic [31:0]       r_regs [NUM_REGS-1];

  logic [31:0]       w_word_addr;
  logic [3:0]        w_strb;
  logic              w_misalign, w_ready_out, w_accept, w_err, w_complete;
  logic [31:0]       w_rd_word;

  ahblite_byte_strobe u_strobe (
    .i_size     (HSIZE),
    .i_addr     (HADDR[1:0]),
    .o_strb     (w_strb),
    .o_misalign (w_misalign)
  );

  assign w_word_addr = {2'b00, HADDR[31:2]};
  assign w_ready_out = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept    = HSEL && HREADY && w_ready_out &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  // A pending good transfer completes in the first IDLE cycle after its wait states.
  assign w_complete  = r_pend && (r_state == ST_IDLE);

  always_comb begin
    w_err = (w_word_addr >= NUM_REGS) || (HSIZE > HSIZE_WORD) || w_misalign ||
            (HWRITE && (w_word_addr == NUM_REGS - 1));
`ifndef AHBLITE_REGFILE_BYTE_WRITE_EN
    w_err = w_err || (HWRITE && (HSIZE != HSIZE_WORD));
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - 4'd1;
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_write <= 1'b0;
      r_idx   <= '0;
      r_strb  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_pend  <= !w_err;
        r_idx   <= HADDR[2 +: IDXW];
        r_write <= HWRITE;
        r_strb  <= w_strb;
      end else if (w_complete) begin
        r_pend  <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= '0;
    end else if (w_complete && r_write) begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
        if (r_idx == IDXW'(i)) begin
          for (int unsigned j = 0; j < 4; j++) begin
            if (r_strb[j]) r_regs[i][8*j +: 8] <= HWDATA[8*j +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    w_rd_word = status_in;
    ctrl_out  = '0;
    for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
      if (r_idx == IDXW'(i)) w_rd_word = r_regs[i];
      ctrl_out[32*i +: 32] = r_regs[i];
    end
  end

  assign HREADYOUT = w_ready_out;
  assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (w_complete && !r_write) ? w_rd_word : '0;

endmodule

// File: tb/tb_ahblite_regfile_slave.sv
// Two responders (WAIT_STATES=1 and 0) behind a small AHB-Lite response mux; scoreboarded.
module tb_ahblite_regfile_slave;
  import ahblite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE, hsel0, hsel1;
  logic        rdy0, rdy1, resp0, resp1;
  logic [31:0] rd0, rd1;
  logic [32*7-1:0] ctrl0, ctrl1;
  logic        r_dsel;
  logic        hready_m, hresp_m;
  logic [31:0] hrdata_m;

  always #5 HCLK = ~HCLK;

  assign hready_m = r_dsel ? rdy1  : rdy0;
  assign hresp_m  = r_dsel ? resp1 : resp0;
  assign hrdata_m = r_dsel ? rd1   : rd0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)      r_dsel <= 1'b0;
    else if (hready_m) r_dsel <= hsel1;
  end

  ahblite_regfile_slave #(.NUM_REGS(8), .WAIT_STATES(1)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(hready_m), .HWDATA(HWDATA),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0), .ctrl_out(ctrl0),
    .status_in(32'hA5A5A5A5)
  );

  ahblite_regfile_slave #(.NUM_REGS(8), .WAIT_STATES(0)) u_dut_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(hready_m), .HWDATA(HWDATA),
    .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rd1), .ctrl_out(ctrl1),
    .status_in(32'h0BADF00D)
  );

  typedef struct {
    bit          err;
    bit          wr;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef AHBLITE_REGFILE_BYTE_WRITE_EN
  localparam bit BW = 1'b1;
`else
  localparam bit BW = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one transfer; returns just after its address phase is accepted.
  task automatic xfer(input bit s, input logic [31:0] addr, input logic [2:0] size,
                      input bit wr, input logic [31:0] wdata, input bit err,
                      input logic [31:0] rexp);
    exp_t e;
    int   n = 0;
    hsel0 = !s; hsel1 = s; HADDR = addr; HSIZE = size; HWRITE = wr; HTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    while (!hready_m && n < 50) begin
      n++;
      @(negedge HCLK);
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got %0d stalled cycles expected ready", n);
    end
    @(posedge HCLK);
    e.err   = err;
    e.wr    = wr;
    e.rdata = (wr || err) ? 32'h0 : rexp;
    e.waits = (err || !s) ? 1 : 0;
    q.push_back(e);
    #1;
    HTRANS = HTRANS_IDLE; hsel0 = 1'b0; hsel1 = 1'b0; HWDATA = wdata;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge HCLK);
      n++;
    end
    #1;
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  // Response monitor
  bit   dp = 1'b0;
  int   stalls = 0;
  logic stall_resp = 1'b0;
  exp_t me;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      q.delete();
      dp = 1'b0;
      stalls = 0;
    end else begin
      if (dp) begin
        if (!hready_m) begin
          stalls++;
          if (stalls == 1) stall_resp = hresp_m;
        end else if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_completion: got completion expected none");
          stalls = 0;
        end else begin
          me = q.pop_front();
          check("resp", {31'b0, hresp_m}, {31'b0, me.err});
          check("waits", stalls, me.waits);
          check("rdata", hrdata_m, me.rdata);
          if (me.waits > 0) check("stall_resp", {31'b0, stall_resp}, {31'b0, me.err});
          stalls = 0;
        end
      end
      if (hready_m) dp = (hsel0 || hsel1) && HTRANS[1];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0; HTRANS = HTRANS_IDLE; hsel0 = 1'b0; hsel1 = 1'b0;
    HADDR = '0; HSIZE = HSIZE_WORD; HWRITE = 1'b0; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_ready", {31'b0, rdy0}, 32'h1);
    check("rst_resp", {31'b0, resp0}, 32'h0);
    check("rst_rdata", rd0, 32'h0);
    check("rst_ctrl", {31'b0, |ctrl0}, 32'h0);
    check("rst_ready_ws0", {31'b0, rdy1}, 32'h1);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;

    // one wait state write
    xfer(0, 32'h04, HSIZE_WORD, 1, 32'hDEADBEEF, 0, 0);
    drain();
    check("word1_write", ctrl0[32*1 +: 32], 32'hDEADBEEF);

    // zero-wait back-to-back write then read
    xfer(1, 32'h08, HSIZE_WORD, 1, 32'h12345678, 0, 0);
    xfer(1, 32'h08, HSIZE_WORD, 0, 0, 0, 32'h12345678);
    drain();
    check("ws0_word2", ctrl1[32*2 +: 32], 32'h12345678);

    // back-to-back with wait states, then a sub-word read returning the full word
    xfer(0, 32'h10, HSIZE_WORD, 1, 32'hCAFEF00D, 0, 0);
    xfer(0, 32'h10, HSIZE_WORD, 0, 0, 0, 32'hCAFEF00D);
    xfer(0, 32'h12, HSIZE_HALF, 0, 0, 0, 32'hCAFEF00D);
    drain();

    // out-of-range, status write, status reads
    xfer(0, 32'h20, HSIZE_WORD, 0, 0, 1, 0);
    xfer(0, 32'h1C, HSIZE_WORD, 1, 32'h11111111, 1, 0);
    xfer(0, 32'h1C, HSIZE_WORD, 0, 0, 0, 32'hA5A5A5A5);
    xfer(1, 32'h1F, HSIZE_BYTE, 0, 0, 0, 32'h0BADF00D);
    xfer(1, 32'h20, HSIZE_WORD, 0, 0, 1, 0);
    drain();
    check("no_change_w1", ctrl0[32*1 +: 32], 32'hDEADBEEF);
    check("no_change_w4", ctrl0[32*4 +: 32], 32'hCAFEF00D);

    // sub-word writes depend on the build option
    xfer(0, 32'h00, HSIZE_WORD, 1, 32'hFFFFFFFF, 0, 0);
    xfer(0, 32'h02, HSIZE_BYTE, 1, 32'h003C0000, !BW, 0);
    xfer(0, 32'h00, HSIZE_WORD, 0, 0, 0, BW ? 32'hFF3CFFFF : 32'hFFFFFFFF);
    xfer(1, 32'h00, HSIZE_HALF, 1, 32'h0000BEEF, !BW, 0);
    drain();
    check("byte_write_w0", ctrl0[0 +: 32], BW ? 32'hFF3CFFFF : 32'hFFFFFFFF);
    check("half_write_ws0", ctrl1[0 +: 32], BW ? 32'h0000BEEF : 32'h0);

    // size and alignment errors
    xfer(0, 32'h04, 3'b011, 0, 0, 1, 0);
    xfer(0, 32'h06, HSIZE_HALF, 0, 0, 0, 32'hDEADBEEF);
    xfer(0, 32'h05, HSIZE_HALF, 0, 0, 1, 0);
    xfer(0, 32'h01, HSIZE_WORD, 0, 0, 1, 0);
    drain();

    // BUSY is not accepted
    HTRANS = HTRANS_BUSY; hsel0 = 1'b1; HADDR = 32'h20; HWRITE = 1'b0;
    @(posedge HCLK);
    #1;
    HTRANS = HTRANS_IDLE; hsel0 = 1'b0;
    check("busy_ready", {31'b0, rdy0}, 32'h1);
    check("busy_resp", {31'b0, resp0}, 32'h0);

    // reset while a write sits in its wait state
    xfer(0, 32'h0C, HSIZE_WORD, 1, 32'h00000055, 0, 0);
    check("in_wait", {31'b0, rdy0}, 32'h0);
    HRESETn = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, rdy0}, 32'h1);
    check("rst_mid_resp", {31'b0, resp0}, 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    check("abandoned_w3", ctrl0[32*3 +: 32], 32'h0);
    check("reset_w1", ctrl0[32*1 +: 32], 32'h0);
    xfer(0, 32'h0C, HSIZE_WORD, 0, 0, 0, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
